// File: rtl/gpio_bus_arbiter_pkg.sv
// Shared types and sizes for the GPIO register-port arbiter.
// GPIO_SIZE / BUS_WIDTH / BUS_ACC_WIDTH mirror the controller's register port.
package gpio_bus_arbiter_pkg;

    localparam int GPIO_SIZE     = 16;
    localparam int BUS_WIDTH     = 32;
    localparam int BUS_ACC_WIDTH = 2;
    localparam int ADDR_W        = $clog2(GPIO_SIZE);

    // 2-bit state encodings shared with the controller-side tooling
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // Qualifiers latched from the winning master at grant time
    typedef struct packed {
        logic [ADDR_W-1:0]        addr;
        logic                     w_rb;
        logic [BUS_ACC_WIDTH-1:0] acc;
        logic [BUS_WIDTH-1:0]     wdata;
    } bus_cmd_t;

    function automatic bus_cmd_t make_cmd(
        input logic [ADDR_W-1:0]        addr,
        input logic                     w_rb,
        input logic [BUS_ACC_WIDTH-1:0] acc,
        input logic [BUS_WIDTH-1:0]     wdata
    );
        bus_cmd_t c;
        c.addr  = addr;
        c.w_rb  = w_rb;
        c.acc   = acc;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/gpio_bus_arbiter_if.sv
// Bundle of both master ports plus the controller-side port.
// slave  : the arbiter's view (serves the masters, drives the controller)
// master : the environment's view (masters and controller)
interface gpio_bus_arbiter_if;
    import gpio_bus_arbiter_pkg::*;

    logic [ADDR_W-1:0]        m0_addr,  m1_addr;
    logic                     m0_w_rb,  m1_w_rb;
    logic [BUS_ACC_WIDTH-1:0] m0_acc,   m1_acc;
    logic [BUS_WIDTH-1:0]     m0_wdata, m1_wdata;
    logic                     m0_req,   m1_req;
    logic                     m0_resp,  m1_resp;
    logic                     m0_fault, m1_fault;
    logic [BUS_WIDTH-1:0]     m_rdata;

    logic [ADDR_W-1:0]        s_addr;
    logic                     s_w_rb;
    logic [BUS_ACC_WIDTH-1:0] s_acc;
    logic [BUS_WIDTH-1:0]     s_wdata;
    logic                     s_req;
    logic [BUS_WIDTH-1:0]     s_rdata;
    logic                     s_resp;
    logic                     s_fault;

    modport slave (
        input  m0_addr, m0_w_rb, m0_acc, m0_wdata, m0_req,
        input  m1_addr, m1_w_rb, m1_acc, m1_wdata, m1_req,
        output m0_resp, m0_fault, m1_resp, m1_fault, m_rdata,
        output s_addr, s_w_rb, s_acc, s_wdata, s_req,
        input  s_rdata, s_resp, s_fault
    );

    modport master (
        output m0_addr, m0_w_rb, m0_acc, m0_wdata, m0_req,
        output m1_addr, m1_w_rb, m1_acc, m1_wdata, m1_req,
        input  m0_resp, m0_fault, m1_resp, m1_fault, m_rdata,
        input  s_addr, s_w_rb, s_acc, s_wdata, s_req,
        output s_rdata, s_resp, s_fault
    );

endinterface

// File: rtl/gpio_arb_rr.sv
// Combinational 2-way round-robin picker. On a tie the master other than
// `last` wins; a lone requester always wins.
module gpio_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       valid
);

    // one-hot grant selection
    always_comb begin
        gnt   = 2'b00;
        valid = |req;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Two-master arbiter in front of the GPIO controller register port.
// One transaction outstanding at a time; resp/fault are routed combinationally
// to the granted master only.
// Optional build macro: GPIO_ARB_TIMEOUT_EN adds a WAIT watchdog that faults
// the access on the TIMEOUT-th WAIT cycle without a response.
module gpio_bus_arbiter
    import gpio_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rstn,
    gpio_bus_arbiter_if.slave   bus
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("gpio_bus_arbiter: TIMEOUT must be in 1..255");
    end

    arb_state_e state_q, state_d;
    logic       last_q,  last_d;
    logic       grant_q, grant_d;   // 0 = m0, 1 = m1
    bus_cmd_t   cmd_q,   cmd_d;

    logic [1:0] rr_gnt;
    logic       rr_valid;
    logic       resp_hit, fault_hit;

`ifdef GPIO_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt_q, wd_cnt_d;
`endif

    gpio_arb_rr u_rr (
        .req   ({bus.m1_req, bus.m0_req}),
        .last  (last_q),
        .gnt   (rr_gnt),
        .valid (rr_valid)
    );

    // next-state, grant capture and completion decode
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        cmd_d     = cmd_q;
        resp_hit  = 1'b0;
        fault_hit = 1'b0;
`ifdef GPIO_ARB_TIMEOUT_EN
        wd_cnt_d  = wd_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    grant_d = rr_gnt[1];
                    last_d  = rr_gnt[1];
                    if (rr_gnt[0]) begin
                        cmd_d = make_cmd(bus.m0_addr, bus.m0_w_rb, bus.m0_acc, bus.m0_wdata);
                    end else begin
                        cmd_d = make_cmd(bus.m1_addr, bus.m1_w_rb, bus.m1_acc, bus.m1_wdata);
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.s_fault) begin
                    fault_hit = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_WAIT;
`ifdef GPIO_ARB_TIMEOUT_EN
                    wd_cnt_d  = 8'd0;
`endif
                end
            end
            ST_WAIT: begin
                if (bus.s_resp) begin
                    resp_hit = 1'b1;
                    state_d  = ST_IDLE;
                end
`ifdef GPIO_ARB_TIMEOUT_EN
                else if (wd_cnt_q == 8'(TIMEOUT - 1)) begin
                    // this cycle's increment would reach TIMEOUT: give up
                    fault_hit = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and latched-command registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            cmd_q   <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
            wd_cnt_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cmd_q   <= cmd_d;
`ifdef GPIO_ARB_TIMEOUT_EN
            wd_cnt_q <= wd_cnt_d;
`endif
        end
    end

    // outputs are held quiet while reset is asserted, even mid-transaction
    assign bus.s_req    = rstn && (state_q == ST_ISSUE);
    assign bus.s_addr   = cmd_q.addr;
    assign bus.s_w_rb   = cmd_q.w_rb;
    assign bus.s_acc    = cmd_q.acc;
    assign bus.s_wdata  = cmd_q.wdata;
    assign bus.m_rdata  = bus.s_rdata;
    assign bus.m0_resp  = rstn && resp_hit  && !grant_q;
    assign bus.m1_resp  = rstn && resp_hit  &&  grant_q;
    assign bus.m0_fault = rstn && fault_hit && !grant_q;
    assign bus.m1_fault = rstn && fault_hit &&  grant_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with a small controller stub:
// addresses 0..7 are valid registers, address bit 3 set faults in ISSUE.
module tb_gpio_bus_arbiter;
    import gpio_bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    gpio_bus_arbiter_if bus ();

    gpio_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // controller stub: one-cycle response latency, optional mute
    logic [31:0] regs [8] = '{32'h0000_00A5, 32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        stub_resp_q  = 1'b0;
    logic [31:0] stub_rdata_q = 32'h0;
    logic        mute;
    logic        man_resp;

    assign bus.s_fault = bus.s_req && bus.s_addr[3];
    assign bus.s_resp  = stub_resp_q | man_resp;
    assign bus.s_rdata = stub_rdata_q;

    always @(posedge clk) begin
        stub_resp_q <= 1'b0;
        if (bus.s_req && !bus.s_fault) begin
            stub_resp_q <= !mute;
            if (bus.s_w_rb) regs[bus.s_addr[2:0]] <= bus.s_wdata;
            else            stub_rdata_q <= regs[bus.s_addr[2:0]];
        end
    end

    // back-to-back s_req and fault-pulse monitors
    logic prev_sreq = 1'b0;
    int   dbl_sreq  = 0;
    int   flt_cnt   = 0;
    always @(posedge clk) begin
        if (bus.s_req && prev_sreq) dbl_sreq <= dbl_sreq + 1;
        prev_sreq <= bus.s_req;
    end
    always @(negedge clk) begin
        if (bus.m0_fault || bus.m1_fault) flt_cnt <= flt_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    int flt_snap;

    initial begin
        rstn = 1'b0; mute = 1'b0; man_resp = 1'b0;
        bus.m0_addr = '0; bus.m0_w_rb = 1'b0; bus.m0_acc = '0; bus.m0_wdata = '0; bus.m0_req = 1'b0;
        bus.m1_addr = '0; bus.m1_w_rb = 1'b0; bus.m1_acc = '0; bus.m1_wdata = '0; bus.m1_req = 1'b0;
        tick(); tick();

        // reset values
        chk("rst_s_req",   32'(bus.s_req), 32'd0);
        chk("rst_m0_resp", 32'(bus.m0_resp), 32'd0);
        chk("rst_m1_resp", 32'(bus.m1_resp), 32'd0);
        chk("rst_m0_flt",  32'(bus.m0_fault), 32'd0);
        chk("rst_m1_flt",  32'(bus.m1_fault), 32'd0);
        chk("rst_state",   32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_last",    32'(dut.last_q), 32'd1);
        chk("rst_s_addr",  32'(bus.s_addr), 32'd0);
        chk("rst_s_wdata", bus.s_wdata, 32'd0);
        rstn = 1'b1;
        tick();

        // m0 alone reads addr 0 (4-byte access)
        bus.m0_addr = 4'd0; bus.m0_w_rb = 1'b0; bus.m0_acc = 2'd2; bus.m0_req = 1'b1;
        tick();
        chk("t1_c1_s_req",  32'(bus.s_req), 32'd1);
        chk("t1_c1_s_addr", 32'(bus.s_addr), 32'd0);
        chk("t1_c1_m0resp", 32'(bus.m0_resp), 32'd0);
        tick();
        chk("t1_c2_m0resp", 32'(bus.m0_resp), 32'd1);
        chk("t1_c2_rdata",  bus.m_rdata, 32'h0000_00A5);
        chk("t1_c2_m1resp", 32'(bus.m1_resp), 32'd0);
        bus.m0_req = 1'b0;
        tick();
        chk("t1_c3_s_req",  32'(bus.s_req), 32'd0);
        chk("t1_c3_state",  32'(dut.state_q), 32'(ST_IDLE));

        // short reset puts last back to 1
        rstn = 1'b0; tick(); rstn = 1'b1;
        chk("t2_last_rst", 32'(dut.last_q), 32'd1);

        // tie after reset: m0 first, m1 second; m0 re-raises and loses the repeat tie
        bus.m0_addr = 4'd1; bus.m0_w_rb = 1'b0; bus.m0_req = 1'b1;
        bus.m1_addr = 4'd2; bus.m1_w_rb = 1'b0; bus.m1_acc = 2'd2; bus.m1_req = 1'b1;
        tick();
        chk("t2_c1_s_addr", 32'(bus.s_addr), 32'd1);
        tick();
        chk("t2_c2_m0resp", 32'(bus.m0_resp), 32'd1);
        chk("t2_c2_m1resp", 32'(bus.m1_resp), 32'd0);
        chk("t2_c2_rdata",  bus.m_rdata, 32'h11);
        bus.m0_req = 1'b0;
        tick();
        chk("t2_c3_s_req",  32'(bus.s_req), 32'd0);
        bus.m0_addr = 4'd3; bus.m0_req = 1'b1;
        tick();
        chk("t2_c4_s_addr", 32'(bus.s_addr), 32'd2);
        tick();
        chk("t2_c5_m1resp", 32'(bus.m1_resp), 32'd1);
        chk("t2_c5_m0resp", 32'(bus.m0_resp), 32'd0);
        chk("t2_c5_rdata",  bus.m_rdata, 32'h22);
        bus.m1_req = 1'b0;
        tick();
        tick();
        chk("t2_c7_s_addr", 32'(bus.s_addr), 32'd3);
        tick();
        chk("t2_c8_m0resp", 32'(bus.m0_resp), 32'd1);
        chk("t2_c8_rdata",  bus.m_rdata, 32'h33);
        bus.m0_req = 1'b0;
        tick();

        // m1 writes invalid addr 8: fault in ISSUE
        bus.m1_addr = 4'd8; bus.m1_w_rb = 1'b1; bus.m1_wdata = 32'h5A; bus.m1_req = 1'b1;
        tick();
        chk("t3_c1_m1flt",  32'(bus.m1_fault), 32'd1);
        chk("t3_c1_m1resp", 32'(bus.m1_resp), 32'd0);
        chk("t3_c1_m0flt",  32'(bus.m0_fault), 32'd0);
        bus.m1_req = 1'b0;
        tick();
        chk("t3_c2_state",  32'(dut.state_q), 32'(ST_IDLE));
        chk("t3_c2_m1flt",  32'(bus.m1_fault), 32'd0);
        chk("t3_c2_m1resp", 32'(bus.m1_resp), 32'd0);

        // m0 writes DIR (addr 4) = 0xF while m1 becomes pending to read it back
        bus.m0_addr = 4'd4; bus.m0_w_rb = 1'b1; bus.m0_wdata = 32'hF; bus.m0_req = 1'b1;
        tick();
        chk("t4_c1_s_addr", 32'(bus.s_addr), 32'd4);
        chk("t4_c1_s_w_rb", 32'(bus.s_w_rb), 32'd1);
        chk("t4_c1_wdata",  bus.s_wdata, 32'hF);
        bus.m1_addr = 4'd4; bus.m1_w_rb = 1'b0; bus.m1_req = 1'b1;
        tick();
        chk("t4_c2_m0resp", 32'(bus.m0_resp), 32'd1);
        chk("t4_c2_m1resp", 32'(bus.m1_resp), 32'd0);
        bus.m0_req = 1'b0;
        tick();
        chk("t4_c3_s_req",  32'(bus.s_req), 32'd0);
        tick();
        chk("t4_c4_s_req",  32'(bus.s_req), 32'd1);
        chk("t4_c4_s_w_rb", 32'(bus.s_w_rb), 32'd0);
        tick();
        chk("t4_c5_m1resp", 32'(bus.m1_resp), 32'd1);
        chk("t4_c5_rdata",  bus.m_rdata, 32'hF);
        bus.m1_req = 1'b0;
        tick();

        // reset during WAIT, late s_resp arrives in IDLE
        mute = 1'b1;
        bus.m0_addr = 4'd0; bus.m0_w_rb = 1'b0; bus.m0_req = 1'b1;
        tick();
        tick();
        chk("t5_c2_state",  32'(dut.state_q), 32'(ST_WAIT));
        chk("t5_c2_m0resp", 32'(bus.m0_resp), 32'd0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1; man_resp = 1'b1; bus.m0_req = 1'b0;
        #1;
        chk("t5_c3_m0resp", 32'(bus.m0_resp), 32'd0);
        chk("t5_c3_m1resp", 32'(bus.m1_resp), 32'd0);
        chk("t5_c3_state",  32'(dut.state_q), 32'(ST_IDLE));
        chk("t5_c3_last",   32'(dut.last_q), 32'd1);
        tick();
        man_resp = 1'b0;
        chk("t5_c4_s_req",  32'(bus.s_req), 32'd0);
        chk("t5_c4_state",  32'(dut.state_q), 32'(ST_IDLE));

        // controller never answers
        bus.m0_addr = 4'd1; bus.m0_req = 1'b1;
        tick();
        tick();
        flt_snap = flt_cnt;
`ifdef GPIO_ARB_TIMEOUT_EN
        tick(); tick();
        chk("t6_c4_m0flt",  32'(bus.m0_fault), 32'd0);
        tick();
        chk("t6_c5_m0flt",  32'(bus.m0_fault), 32'd1);
        chk("t6_c5_m0resp", 32'(bus.m0_resp), 32'd0);
        bus.m0_req = 1'b0;
        tick();
        chk("t6_c6_state",  32'(dut.state_q), 32'(ST_IDLE));
`else
        repeat (20) tick();
        chk("t6_wait_state", 32'(dut.state_q), 32'(ST_WAIT));
        chk("t6_no_fault",   32'(flt_cnt - flt_snap), 32'd0);
        man_resp = 1'b1;
        #1;
        chk("t6_late_resp",  32'(bus.m0_resp), 32'd1);
        chk("t6_late_rdata", bus.m_rdata, 32'h11);
        tick();
        man_resp = 1'b0; bus.m0_req = 1'b0;
        chk("t6_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
`endif
        mute = 1'b0;
        tick();

        chk("no_b2b_s_req", 32'(dbl_sreq), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/gpio_bus_arbiter.md
# gpio_bus_arbiter

Two-master arbiter that shares the single register port of the GPIO controller between the CPU data bus (master 0) and a second requester such as a bit-bang/DMA engine (master 1). It sits between the two masters and `gpio_controller`. It serialises accesses with round-robin priority, forwards the controller's one-cycle-latency response and combinational fault to the granted master only, and keeps at most one transaction outstanding.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum WAIT cycles before the watchdog faults the access. Used only with `GPIO_ARB_TIMEOUT_EN`. Range 1..255.

Ports (reset rstn, synchronous, active-low; clock clk):
- `clk` in 1: clock
- `rstn` in 1: synchronous active-low reset
- `mN_addr` in `$clog2(`GPIO_SIZE)` (N=0,1): master N register address
- `mN_w_rb` in 1: master N write(1)/read(0)
- `mN_acc` in `BUS_ACC_WIDTH`: master N access size
- `mN_wdata` in `BUS_WIDTH`: master N write data
- `mN_req` in 1: master N request; held with stable qualifiers until `mN_resp` or `mN_fault`
- `mN_resp` out 1: master N completion pulse
- `mN_fault` out 1: master N fault pulse
- `m_rdata` out `BUS_WIDTH`: read data shared by both masters; valid only with a `mN_resp`
- `s_addr`, `s_w_rb`, `s_acc`, `s_wdata` out: to controller; driven from latched copies
- `s_req` out 1: controller request; exactly one cycle per transaction
- `s_rdata` in `BUS_WIDTH`, `s_resp` in 1, `s_fault` in 1: from controller

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any `mN_req` is set, pick the winner, latch its addr/w_rb/acc/wdata, set `grant`, go to ISSUE.
- Arbitration: round robin with pointer `last`. If both masters request, grant the master other than `last`. A single requester always wins. Update `last` on grant. After reset, `last`=1, so m0 wins the first tie.
- ISSUE: `s_req`=1. If `s_fault`: `m<grant>_fault`=1 in the same cycle (combinational), then go to IDLE. Otherwise go to WAIT.
- WAIT: when `s_resp`, `m<grant>_resp`=1 in the same cycle (combinational), `m_rdata`=`s_rdata`, then go to IDLE.
- The non-granted master never sees resp or fault. Its request stays pending and is re-arbitrated in IDLE.
- Requests are not re-sampled in ISSUE or WAIT. A master that drops `req` before completion still has its transaction completed, and the resp pulse is still driven.
- `m_rdata` = `s_rdata` in every cycle (pass-through). Contents are meaningful only in the resp cycle.
- Reset values: state IDLE, `s_req`=0, all `mN_resp`/`mN_fault`=0, `last`=1, latched qualifiers 0, watchdog counter 0.
- Reset asserted mid-transaction: drop to IDLE next edge. The in-flight access is abandoned with no resp/fault. A late `s_resp` arriving in IDLE is ignored.

## Timing
- Cycle 0: `mN_req` seen in IDLE. Cycle 1: ISSUE, `s_req`=1, fault returned here if invalid. Cycle 2: WAIT, controller `s_resp` → `mN_resp`.
- Valid access latency: 2 cycles from first req cycle to resp. Faulting access latency: 1 cycle.
- Throughput: one transaction per 3 cycles. The master drops `req` the cycle after resp, so IDLE never re-grants a completed request.
- Back-to-back contention: m0 and m1 both requesting at cycle 0 gives m0 resp at cycle 2 and m1 resp at cycle 5.

## Configuration
- `GPIO_ARB_TIMEOUT_EN` defined: an 8-bit counter clears on entering WAIT and increments each WAIT cycle without `s_resp`. When it reaches `TIMEOUT`, pulse `m<grant>_fault` and return to IDLE. A `s_resp` arriving in the same cycle takes precedence, giving resp and no fault.
- Not defined: no counter. WAIT persists until `s_resp`.

## Structure
- `femto.vh` holds `GPIO_SIZE`, `BUS_WIDTH` and `BUS_ACC_WIDTH` (existing), plus new `GPIO_ARB_ST_IDLE/ISSUE/WAIT` state encodings (2 bits).
- Sub-module `gpio_arb_rr`: combinational 2-way round-robin picker. Inputs are the req vector and `last`. Outputs are the grant one-hot and `valid`. Instantiated once.

## Test plan
- m0 alone reads addr 0 with acc=4B; controller returns 0x0000_00A5 → `m0_resp` at cycle 2 with `m_rdata`=0xA5, `m1_resp` stays 0.
- m0 and m1 both request in the same cycle after reset → m0 is served first (resp at cycle 2), m1 second (resp at cycle 5). A repeat tie is then served m1 first.
- m1 writes addr 8 (invalid) → controller faults in ISSUE → `m1_fault` at cycle 1, no `m1_resp`, state back to IDLE at cycle 2.
- m0 writes DIR=0xF while m1 is pending → m1 is granted only after `m0_resp`. `s_req` is never high on two consecutive cycles.
- `rstn` is asserted during WAIT, with `s_resp` arriving the following cycle → no `mN_resp`, state IDLE, `last`=1.
- With `GPIO_ARB_TIMEOUT_EN` and `TIMEOUT`=4, the controller stub never responds → `m0_fault` after 4 WAIT cycles. Without the macro the arbiter stays in WAIT indefinitely.
